// File: rtl/instr_fetch_pkg.sv
// Shared widths, instruction field positions and FSM state encoding for the
// instruction fetch block.
package instr_fetch_pkg;

    localparam int INSTR_W   = 19;
    localparam int OPC_W     = 3;
    localparam int OPND_W    = 8;
    localparam int DEPTH_DEF = 16;
    localparam int AW_DEF    = 4;

    localparam int OPC_MSB   = 18;
    localparam int OPC_LSB   = 16;
    localparam int OPND1_MSB = 15;
    localparam int OPND1_LSB = 8;
    localparam int OPND2_MSB = 7;
    localparam int OPND2_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/instr_fetch_mem.sv
// Program memory: DEPTH x INSTR_W, one write port, one synchronous read port.
// The read register doubles as the instruction register and is the only part reset.
module instr_mem
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rdata only changes on an enabled read, so it holds the last word issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetches prog_len words from program memory starting at address 0 and issues
// them to a CPU stage over a valid/ready handshake, one word per two cycles.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_en,
    input  logic [AW-1:0]      load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               start,
    input  logic [AW:0]        prog_len,
    input  logic               halt,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [AW-1:0]      pc,
    output logic               busy,
    output logic               done,
    output state_e             state
);

    // Handshake: a word transfers on a rising edge where instr_valid and
    // instr_ready are both high; instruction and pc hold while ready is low.

    localparam logic [AW:0] MAX_LEN = DEPTH[AW:0];

    logic [AW:0] len_q;
    logic [AW:0] clamped_len;
    logic        last_word;
    logic        mem_we;
    logic        mem_re;

    assign clamped_len = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
    assign last_word   = ({1'b0, pc} == (len_q - (AW + 1)'(1)));
    assign mem_we      = load_en && (state == ST_IDLE);
    assign mem_re      = (state == ST_FETCH) && !halt;

    instr_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (mem_re),
        .raddr (pc),
        .rdata (instruction)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= '0;
            len_q       <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (halt) begin
            // halt overrides start and any handshake on the same edge
            state       <= ST_IDLE;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        len_q <= clamped_len;
                        pc    <= '0;
                        busy  <= 1'b1;
                        if (clamped_len != '0) begin
                            state <= ST_FETCH;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    instr_valid <= 1'b1;
                    state       <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (last_word) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            pc    <= pc + 1'b1;
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: table-driven run vectors plus hand-written
// sequences for stalls, halt, mid-run reset, loads while busy and length clamping.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               load_en;
    logic [3:0]         load_addr;
    logic [INSTR_W-1:0] load_data;
    logic               start;
    logic [4:0]         prog_len;
    logic               halt;
    logic               instr_ready;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic [3:0]         pc;
    logic               busy;
    logic               done;
    state_e             state;

    int checks = 0;
    int errors = 0;

    logic [INSTR_W-1:0] exp_mem [16];

    typedef struct {
        logic         start;
        logic         halt;
        logic         ready;
        logic [4:0]   len;
        logic         exp_valid;
        logic [18:0]  exp_instr;
        logic [3:0]   exp_pc;
        logic         exp_busy;
        logic         exp_done;
        state_e       exp_state;
    } vec_t;

    vec_t vecs [10];

    instr_fetch #(
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .prog_len    (prog_len),
        .halt        (halt),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_word(input logic [3:0] addr, input logic [18:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        step();
        load_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit fin;
        fin = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (!busy) begin
                fin = 1'b1;
                break;
            end
            step();
        end
        chk({tag, "_idle_timeout"}, 32'(fin), 32'd1);
    endtask

    // Runs a program with instr_ready held high and scores every issued word.
    task automatic run_check(input logic [4:0] len, input int exp_words, input string tag);
        int cnt;
        int dones;
        bit fin;
        cnt   = 0;
        dones = 0;
        fin   = 1'b0;
        start       = 1'b1;
        prog_len    = len;
        instr_ready = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (instr_valid) begin
                chk($sformatf("%s_instr%0d", tag, cnt), 32'(instruction), 32'(exp_mem[cnt[3:0]]));
                chk($sformatf("%s_pc%0d", tag, cnt), 32'(pc), 32'(cnt[3:0]));
                cnt++;
            end
            if (done) dones++;
            if (!busy) begin
                fin = 1'b1;
                break;
            end
            step();
        end
        chk({tag, "_finished"}, 32'(fin), 32'd1);
        chk({tag, "_words"}, 32'(cnt), 32'(exp_words));
        chk({tag, "_done_pulses"}, 32'(dones), 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        load_en     = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        start       = 1'b0;
        prog_len    = '0;
        halt        = 1'b0;
        instr_ready = 1'b0;

        // Main run: 3 words, ready always high, then an empty program.
        vecs[0] = '{1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 19'h0_0000, 4'd0, 1'b1, 1'b0, ST_FETCH};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 19'h1_0305, 4'd0, 1'b1, 1'b0, ST_ISSUE};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 19'h1_0305, 4'd1, 1'b1, 1'b0, ST_FETCH};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 19'h2_0A0B, 4'd1, 1'b1, 1'b0, ST_ISSUE};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 19'h2_0A0B, 4'd2, 1'b1, 1'b0, ST_FETCH};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 19'h7_FF01, 4'd2, 1'b1, 1'b0, ST_ISSUE};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 19'h7_FF01, 4'd2, 1'b1, 1'b1, ST_DONE};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 19'h7_FF01, 4'd2, 1'b0, 1'b0, ST_IDLE};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 19'h7_FF01, 4'd0, 1'b1, 1'b1, ST_DONE};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 19'h7_FF01, 4'd0, 1'b0, 1'b0, ST_IDLE};

        // Reset state
        step();
        step();
        chk("rst_instruction", 32'(instruction), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_state", 32'(state), 32'(ST_IDLE));
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 16; i++) exp_mem[i] = '0;
        exp_mem[0] = 19'h1_0305;
        exp_mem[1] = 19'h2_0A0B;
        exp_mem[2] = 19'h7_FF01;
        for (int i = 0; i < 3; i++) load_word(4'(i), exp_mem[i]);

        for (int i = 0; i < 10; i++) begin
            start       = vecs[i].start;
            halt        = vecs[i].halt;
            instr_ready = vecs[i].ready;
            prog_len    = vecs[i].len;
            step();
            chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_instr", i), 32'(instruction), 32'(vecs[i].exp_instr));
            chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
        end
        start = 1'b0;

        // Stall on the first word for 5 cycles; a start pulse mid-run must be ignored.
        start       = 1'b1;
        prog_len    = 5'd2;
        instr_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d_valid", i), 32'(instr_valid), 32'd1);
            chk($sformatf("stall%0d_instr", i), 32'(instruction), 32'h1_0305);
            chk($sformatf("stall%0d_pc", i), 32'(pc), 32'd0);
            start    = (i == 2);
            prog_len = 5'd0;
            step();
            start = 1'b0;
        end
        chk("stall_state", 32'(state), 32'(ST_ISSUE));
        instr_ready = 1'b1;
        step();
        chk("stall_release_pc", 32'(pc), 32'd1);
        wait_idle("stall");

        // Load attempted while busy must not reach memory.
        start       = 1'b1;
        prog_len    = 5'd3;
        instr_ready = 1'b0;
        step();
        start = 1'b0;
        load_word(4'd1, 19'h0_0000);
        instr_ready = 1'b1;
        wait_idle("busy_load");
        run_check(5'd2, 2, "rerun");

        // Halt in ISSUE at pc=1, coinciding with a handshake.
        start       = 1'b1;
        prog_len    = 5'd3;
        instr_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("halt_pre_pc", 32'(pc), 32'd1);
        chk("halt_pre_valid", 32'(instr_valid), 32'd1);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("halt_state", 32'(state), 32'(ST_IDLE));
        chk("halt_valid", 32'(instr_valid), 32'd0);
        chk("halt_busy", 32'(busy), 32'd0);
        chk("halt_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("halt_after%0d_done", i), 32'(done), 32'd0);
            chk($sformatf("halt_after%0d_valid", i), 32'(instr_valid), 32'd0);
        end

        // halt and start together in IDLE: no run
        start    = 1'b1;
        halt     = 1'b1;
        prog_len = 5'd3;
        step();
        start = 1'b0;
        halt  = 1'b0;
        chk("halt_start_busy", 32'(busy), 32'd0);
        chk("halt_start_state", 32'(state), 32'(ST_IDLE));

        // Asynchronous reset in the middle of a run.
        start       = 1'b1;
        prog_len    = 5'd3;
        instr_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        chk("pre_rst_valid", 32'(instr_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_state", 32'(state), 32'(ST_IDLE));
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_instr", 32'(instruction), 32'd0);
        chk("midrst_pc", 32'(pc), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_check(5'd3, 3, "post_rst");

        // Full-depth program, then an over-length request clamped to 16.
        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = {3'(i % 8), 8'(i * 3 + 1), 8'(8'hF0 ^ 8'(i))};
            load_word(4'(i), exp_mem[i]);
        end
        run_check(5'd16, 16, "full");
        chk("full_last_pc", 32'(pc), 32'd15);
        run_check(5'd20, 16, "clamp");
        chk("clamp_last_pc", 32'(pc), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DEPTH, default 16: number of program-memory entries; power of two.
REQ-002 Parameter AW, default 4: address width, log2(DEPTH).
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 load_en  input  1: program-memory write strobe.
REQ-006 load_addr  input  AW: write address.
REQ-007 load_data  input  19: instruction word written, [18:16] opcode, [15:8] operand1, [7:0] operand2.
REQ-008 start  input  1: begin issuing the program from address 0.
REQ-009 prog_len  input  AW+1: instruction count, legal range 0..DEPTH, sampled on accepted start.
REQ-010 halt  input  1: abort the run.
REQ-011 instr_ready  input  1: downstream CPU stage accepts the presented instruction.
REQ-012 instruction  output  19: instruction presented to the CPU stage.
REQ-013 instr_valid  output  1: instruction holds a valid word.
REQ-014 pc  output  AW: address of the current instruction.
REQ-015 busy  output  1: high in any state other than IDLE.
REQ-016 done  output  1: one-cycle pulse at end of run.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, ISSUE and DONE.
REQ-018 The program memory SHALL have a synchronous read with 1-cycle latency.
REQ-019 In IDLE, when load_en=1, the block SHALL write load_data to load_addr on that edge.
REQ-020 In states other than IDLE, load_en SHALL be ignored and memory SHALL be unchanged.
REQ-021 In IDLE, on start=1 with halt=0, the block SHALL latch prog_len and clear pc to 0.
REQ-022 On that accepted start, the FSM SHALL go to FETCH if prog_len!=0, else to DONE.
REQ-023 In FETCH, the block SHALL read mem[pc], load instruction, set instr_valid=1 and go to ISSUE next cycle.
REQ-024 First instr_valid SHALL therefore assert 2 cycles after the start edge.
REQ-025 In ISSUE, instruction and pc SHALL hold stable while instr_ready=0.
REQ-026 The handshake SHALL complete on an edge with instr_valid=1 and instr_ready=1.
REQ-027 On handshake with pc==latched_len-1, the block SHALL clear instr_valid and go to DONE.
REQ-028 On any other handshake, the block SHALL clear instr_valid, increment pc and go to FETCH.
REQ-029 Steady-state throughput SHALL be 1 instruction per 2 cycles.
REQ-030 With prog_len=DEPTH, pc SHALL reach DEPTH-1, end the run, and not wrap.
REQ-031 DONE SHALL assert done=1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-032 start outside IDLE SHALL be ignored.
REQ-033 prog_len > DEPTH SHALL be clamped to DEPTH.
REQ-034 halt=1 in any state SHALL force IDLE on the next edge, with instr_valid=0 and done not pulsed.
REQ-035 halt and start together in IDLE: halt SHALL win and no run starts.
REQ-036 halt SHALL beat a simultaneous handshake: the handshake counts as accepted downstream, but no further instruction is issued.
REQ-037 instruction SHALL keep its last value after instr_valid drops; consumers qualify it with instr_valid.

Reset
REQ-038 While rst_n=0: state=IDLE, pc=0, instruction=0, instr_valid=0, busy=0, done=0, latched_len=0.
REQ-039 Program-memory contents SHALL NOT be cleared by reset.
REQ-040 Reset mid-run SHALL abandon the run immediately, without a done pulse.

Structure
REQ-041 A shared package SHALL hold INSTR_W=19, OPC_W=3, OPND_W=8, DEPTH/AW defaults and the FSM state enum.
REQ-042 The package SHALL also hold the opcode field position constants.
REQ-043 The program memory SHALL be a sub-module instr_mem: DEPTH x 19, one write port, one synchronous read port.
REQ-044 instruction SHALL connect directly to the CPU stage's instruction input.

Verification
REQ-045 Load mem[0..2]=19'h1_0305, 19'h2_0A0B, 19'h7_FF01; start with prog_len=3, instr_ready=1 -> words issued in order at cycles +2, +4, +6; done pulses at +7.
REQ-046 prog_len=2, instr_ready low for 5 cycles on the first word -> instruction=19'h1_0305 and pc=0 held stable for all 5 cycles.
REQ-047 start with prog_len=0 -> busy for 1 cycle, done pulse, instr_valid never asserted.
REQ-048 Load attempted while busy (addr 1, data 19'h0_0000) -> later re-run still issues 19'h2_0A0B at pc=1.
REQ-049 halt asserted in ISSUE with pc=1 -> next cycle state IDLE, instr_valid=0, no done pulse.
REQ-050 rst_n dropped mid-run -> immediate IDLE with all outputs 0; memory intact, and rerun issues 19'h1_0305 first.
